// File: rtl/cpu_sequencer_if.sv
// Control bundle between the sequencer and the datapath.
// The sequencer takes the master view. The datapath (or the bench) takes the slave view.
interface cpu_sequencer_if;
  logic       i_run;
  logic [3:0] i_opcode;
  logic       i_carry;
  logic       i_zero;
  logic       o_pc_cntn, o_pc_den, o_pc_din;
  logic       o_mar_inn;
  logic       o_ram_outn, o_ram_inn;
  logic       o_ir_inn, o_ir_outn;
  logic       o_a_inn, o_a_outn, o_b_inn;
  logic       o_alu_outn, o_flags_inn, o_out_inn;
  logic       o_alu_sub;
  logic       o_halt;
  logic [2:0] o_step;

  modport master (
    input  i_run, i_opcode, i_carry, i_zero,
    output o_pc_cntn, o_pc_den, o_pc_din, o_mar_inn, o_ram_outn, o_ram_inn,
           o_ir_inn, o_ir_outn, o_a_inn, o_a_outn, o_b_inn, o_alu_outn,
           o_flags_inn, o_out_inn, o_alu_sub, o_halt, o_step
  );

  modport slave (
    output i_run, i_opcode, i_carry, i_zero,
    input  o_pc_cntn, o_pc_den, o_pc_din, o_mar_inn, o_ram_outn, o_ram_inn,
           o_ir_inn, o_ir_outn, o_a_inn, o_a_outn, o_b_inn, o_alu_outn,
           o_flags_inn, o_out_inn, o_alu_sub, o_halt, o_step
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute microcycle sequencer for the 8-bit bus CPU.
// Registered state/step. Strobes are decoded combinationally from the
// current step, the opcode and the flags. Each step enables at most one bus driver.
module cpu_sequencer (
  input  logic               i_clk,
  input  logic               i_rstn,
  cpu_sequencer_if.master    bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                         OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6,
                         OP_JC  = 4'h7, OP_JZ  = 4'h8, OP_OUT = 4'hE,
                         OP_HLT = 4'hF;

  state_t     state;
  logic [2:0] step;
  logic       last;

  // Last microstep of the current instruction: memory ops end at T3, ALU ops at T4
  always_comb begin
    last = 1'b0;
    if (step == 3'd2)
      last = !(bus.i_opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_STA});
    else if (step == 3'd3)
      last = (bus.i_opcode inside {OP_LDA, OP_STA});
    else if (step >= 3'd4)
      last = 1'b1;
  end

  // Control FSM: i_run only matters in IDLE and at an instruction boundary
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= S_IDLE;
      step  <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          step <= 3'd0;
          if (bus.i_run) state <= S_RUN;
        end
        S_RUN: begin
          if (last) begin
            step <= 3'd0;
            if (step == 3'd2 && bus.i_opcode == OP_HLT) state <= S_HALT;
            else if (!bus.i_run)                       state <= S_IDLE;
          end else begin
            step <= step + 3'd1;
          end
        end
        S_HALT: step <= 3'd0;
        default: begin
          state <= S_IDLE;
          step  <= 3'd0;
        end
      endcase
    end
  end

  // Strobe decode: everything inactive outside RUN
  always_comb begin
    bus.o_pc_cntn   = 1'b1;
    bus.o_pc_den    = 1'b1;
    bus.o_pc_din    = 1'b1;
    bus.o_mar_inn   = 1'b1;
    bus.o_ram_outn  = 1'b1;
    bus.o_ram_inn   = 1'b1;
    bus.o_ir_inn    = 1'b1;
    bus.o_ir_outn   = 1'b1;
    bus.o_a_inn     = 1'b1;
    bus.o_a_outn    = 1'b1;
    bus.o_b_inn     = 1'b1;
    bus.o_alu_outn  = 1'b1;
    bus.o_flags_inn = 1'b1;
    bus.o_out_inn   = 1'b1;
    bus.o_alu_sub   = 1'b0;
    if (state == S_RUN) begin
      case (step)
        3'd0: begin
          bus.o_pc_den  = 1'b0;
          bus.o_mar_inn = 1'b0;
        end
        3'd1: begin
          bus.o_ram_outn = 1'b0;
          bus.o_ir_inn   = 1'b0;
          bus.o_pc_cntn  = 1'b0;
        end
        3'd2: begin
          case (bus.i_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              bus.o_ir_outn = 1'b0;
              bus.o_mar_inn = 1'b0;
            end
            OP_LDI: begin
              bus.o_ir_outn = 1'b0;
              bus.o_a_inn   = 1'b0;
            end
            OP_JMP: begin
              bus.o_ir_outn = 1'b0;
              bus.o_pc_din  = 1'b0;
            end
            OP_JC, OP_JZ: begin
              if ((bus.i_opcode == OP_JC) ? bus.i_carry : bus.i_zero) begin
                bus.o_ir_outn = 1'b0;
                bus.o_pc_din  = 1'b0;
              end
            end
            OP_OUT: begin
              bus.o_a_outn  = 1'b0;
              bus.o_out_inn = 1'b0;
            end
            default: ;
          endcase
        end
        3'd3: begin
          case (bus.i_opcode)
            OP_LDA: begin
              bus.o_ram_outn = 1'b0;
              bus.o_a_inn    = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              bus.o_ram_outn = 1'b0;
              bus.o_b_inn    = 1'b0;
            end
            OP_STA: begin
              bus.o_a_outn  = 1'b0;
              bus.o_ram_inn = 1'b0;
            end
            default: ;
          endcase
        end
        3'd4: begin
          if (bus.i_opcode inside {OP_ADD, OP_SUB}) begin
            bus.o_alu_outn  = 1'b0;
            bus.o_a_inn     = 1'b0;
            bus.o_flags_inn = 1'b0;
            bus.o_alu_sub   = (bus.i_opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs
  always_comb begin
    bus.o_halt = (state == S_HALT);
    bus.o_step = (state == S_RUN) ? step : 3'd0;
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-step strobe patterns, halt, run drop,
// and a random phase that checks bus-driver exclusivity and reset values.
module tb_cpu_sequencer;

  logic i_clk = 1'b0;
  logic i_rstn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  cpu_sequencer_if bus ();

  cpu_sequencer dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus.master)
  );

  always #5 i_clk = ~i_clk;

  // Strobe bit masks; the expected strobe word is ~(OR of the active masks)
  localparam logic [13:0] PCC = 14'h2000, PCD = 14'h1000, PCI = 14'h0800,
                          MARI = 14'h0400, RAMO = 14'h0200, RAMI = 14'h0100,
                          IRI = 14'h0080, IRO = 14'h0040, AI = 14'h0020,
                          AO = 14'h0010, BI = 14'h0008, ALUO = 14'h0004,
                          FLI = 14'h0002, OUTI = 14'h0001, NONE = 14'h0000;

  wire [13:0] strb = {bus.o_pc_cntn, bus.o_pc_den, bus.o_pc_din, bus.o_mar_inn,
                      bus.o_ram_outn, bus.o_ram_inn, bus.o_ir_inn, bus.o_ir_outn,
                      bus.o_a_inn, bus.o_a_outn, bus.o_b_inn, bus.o_alu_outn,
                      bus.o_flags_inn, bus.o_out_inn};
  wire [4:0]  drv  = {bus.o_pc_den, bus.o_ram_outn, bus.o_ir_outn,
                      bus.o_a_outn, bus.o_alu_outn};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Check every output against one expected state
  task automatic exp_now(input string tag, input logic [13:0] act, input logic [2:0] st,
                         input logic sub, input logic hlt);
    chk({tag, ".strb"}, {2'b00, strb}, {2'b00, ~act});
    chk({tag, ".step"}, {13'd0, bus.o_step}, {13'd0, st});
    chk({tag, ".sub"},  {15'd0, bus.o_alu_sub}, {15'd0, sub});
    chk({tag, ".halt"}, {15'd0, bus.o_halt}, {15'd0, hlt});
  endtask

  task automatic exp_cyc(input string tag, input logic [13:0] act, input logic [2:0] st,
                         input logic sub, input logic hlt);
    cyc();
    exp_now(tag, act, st, sub, hlt);
  endtask

  initial begin
    bus.i_run = 1'b0; bus.i_opcode = 4'h0; bus.i_carry = 1'b0; bus.i_zero = 1'b0;
    #2;
    exp_now("reset", NONE, 3'd0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    bus.i_run = 1'b1; bus.i_opcode = 4'h5;
    #1;
    exp_now("idle", NONE, 3'd0, 1'b0, 1'b0);

    // LDI: 3 cycles
    exp_cyc("ldi.t0", PCD | MARI, 3'd0, 1'b0, 1'b0);
    exp_cyc("ldi.t1", RAMO | IRI | PCC, 3'd1, 1'b0, 1'b0);
    exp_cyc("ldi.t2", IRO | AI, 3'd2, 1'b0, 1'b0);
    exp_cyc("sub.t0", PCD | MARI, 3'd0, 1'b0, 1'b0);
    bus.i_opcode = 4'h3;
    // SUB: 5 cycles, subtract only in T4
    exp_cyc("sub.t1", RAMO | IRI | PCC, 3'd1, 1'b0, 1'b0);
    exp_cyc("sub.t2", IRO | MARI, 3'd2, 1'b0, 1'b0);
    exp_cyc("sub.t3", RAMO | BI, 3'd3, 1'b0, 1'b0);
    exp_cyc("sub.t4", ALUO | AI | FLI, 3'd4, 1'b1, 1'b0);
    exp_cyc("jc0.t0", PCD | MARI, 3'd0, 1'b0, 1'b0);
    bus.i_opcode = 4'h7; bus.i_carry = 1'b0;
    exp_cyc("jc0.t1", RAMO | IRI | PCC, 3'd1, 1'b0, 1'b0);
    exp_cyc("jc0.t2", NONE, 3'd2, 1'b0, 1'b0);
    exp_cyc("jc1.t0", PCD | MARI, 3'd0, 1'b0, 1'b0);
    bus.i_carry = 1'b1;
    exp_cyc("jc1.t1", RAMO | IRI | PCC, 3'd1, 1'b0, 1'b0);
    exp_cyc("jc1.t2", IRO | PCI, 3'd2, 1'b0, 1'b0);
    exp_cyc("jz0.t0", PCD | MARI, 3'd0, 1'b0, 1'b0);
    bus.i_opcode = 4'h8; bus.i_zero = 1'b0;
    exp_cyc("jz0.t1", RAMO | IRI | PCC, 3'd1, 1'b0, 1'b0);
    exp_cyc("jz0.t2", NONE, 3'd2, 1'b0, 1'b0);
    exp_cyc("sta.t0", PCD | MARI, 3'd0, 1'b0, 1'b0);
    bus.i_opcode = 4'h4;
    exp_cyc("sta.t1", RAMO | IRI | PCC, 3'd1, 1'b0, 1'b0);
    exp_cyc("sta.t2", IRO | MARI, 3'd2, 1'b0, 1'b0);
    exp_cyc("sta.t3", AO | RAMI, 3'd3, 1'b0, 1'b0);
    exp_cyc("lda.t0", PCD | MARI, 3'd0, 1'b0, 1'b0);
    bus.i_opcode = 4'h1;
    exp_cyc("lda.t1", RAMO | IRI | PCC, 3'd1, 1'b0, 1'b0);
    exp_cyc("lda.t2", IRO | MARI, 3'd2, 1'b0, 1'b0);
    exp_cyc("lda.t3", RAMO | AI, 3'd3, 1'b0, 1'b0);
    exp_cyc("out.t0", PCD | MARI, 3'd0, 1'b0, 1'b0);
    bus.i_opcode = 4'hE;
    exp_cyc("out.t1", RAMO | IRI | PCC, 3'd1, 1'b0, 1'b0);
    exp_cyc("out.t2", AO | OUTI, 3'd2, 1'b0, 1'b0);
    exp_cyc("add.t0", PCD | MARI, 3'd0, 1'b0, 1'b0);
    bus.i_opcode = 4'h2;
    // ADD with i_run dropped in T1: finishes, then IDLE
    exp_cyc("add.t1", RAMO | IRI | PCC, 3'd1, 1'b0, 1'b0);
    bus.i_run = 1'b0;
    exp_cyc("add.t2", IRO | MARI, 3'd2, 1'b0, 1'b0);
    exp_cyc("add.t3", RAMO | BI, 3'd3, 1'b0, 1'b0);
    exp_cyc("add.t4", ALUO | AI | FLI, 3'd4, 1'b0, 1'b0);
    exp_cyc("add.idle", NONE, 3'd0, 1'b0, 1'b0);
    exp_cyc("add.idle2", NONE, 3'd0, 1'b0, 1'b0);
    bus.i_run = 1'b1; bus.i_opcode = 4'hF;
    exp_cyc("hlt.t0", PCD | MARI, 3'd0, 1'b0, 1'b0);
    exp_cyc("hlt.t1", RAMO | IRI | PCC, 3'd1, 1'b0, 1'b0);
    exp_cyc("hlt.t2", NONE, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) exp_cyc("halted", NONE, 3'd0, 1'b0, 1'b1);
    i_rstn = 1'b0;
    #1;
    exp_now("hlt.rst", NONE, 3'd0, 1'b0, 1'b0);
    #1;
    i_rstn = 1'b1;

    // Random opcodes/flags/run with occasional async resets
    for (int i = 0; i < 10000; i++) begin
      cyc();
      chk("busx", {15'd0, ($countones(~drv) > 1)}, 16'd0);
      bus.i_opcode = 4'($urandom_range(0, 15));
      bus.i_carry  = 1'($urandom_range(0, 1));
      bus.i_zero   = 1'($urandom_range(0, 1));
      bus.i_run    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 149) == 0) begin
        i_rstn = 1'b0;
        #1;
        exp_now("rnd.rst", NONE, 3'd0, 1'b0, 1'b0);
        #1;
        i_rstn = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
